// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seqdet_pkg;

  typedef enum logic [0:0] {
    SD_IDLE = 1'b0,
    SD_RUN  = 1'b1
  } sd_state_e;

  localparam int unsigned SEQDET_MASK_W = 32;

  // Low-order mask with the bottom len bits set; callers truncate to their pattern width.
  function automatic logic [SEQDET_MASK_W-1:0] len_mask(input int unsigned len);
    logic [SEQDET_MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SEQDET_MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seqdet_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime pattern/length and overlap selection.
// Optional saturating match counter enabled by defining SEQDET_MATCH_CNT_EN.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter  int unsigned PAT_W = 8,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cnt_clr,
  output logic             armed,
  output logic             match,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_cnt
);

  sd_state_e        state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             match_q;
  logic             cfg_err_q, cfg_err_d;
  logic             hit_c;

  logic [PAT_W-1:0] hist_shift_c;
  logic [LEN_W-1:0] fill_inc_c;
  logic [PAT_W-1:0] run_mask_c;
  logic [PAT_W-1:0] load_mask_c;
  logic             len_ok_c;

  assign hist_shift_c = {hist_q[PAT_W-2:0], in_bit};
  assign fill_inc_c   = (fill_q >= LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
  assign run_mask_c   = PAT_W'(len_mask(32'(len_q)));
  assign load_mask_c  = PAT_W'(len_mask(32'(pat_len)));
  assign len_ok_c     = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SD_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      match_q   <= hit_c;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Loads take priority over data; an illegal load only raises cfg_err.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    cfg_err_d = 1'b0;
    hit_c     = 1'b0;

    if (pat_load) begin
      if (len_ok_c) begin
        pat_d   = pat_in & load_mask_c;
        len_d   = pat_len;
        hist_d  = '0;
        fill_d  = '0;
        state_d = SD_RUN;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        SD_RUN: begin
          if (in_valid) begin
            hist_d = hist_shift_c;
            fill_d = fill_inc_c;
            if ((fill_inc_c >= len_q) && ((hist_shift_c & run_mask_c) == pat_q)) begin
              hit_c = 1'b1;
              // Non-overlapping mode forces a full refill before the next hit.
              if (!overlap) fill_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign armed   = (state_q == SD_RUN);
  assign match   = match_q;
  assign cfg_err = cfg_err_q;

`ifdef SEQDET_MATCH_CNT_EN
  seqdet_sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (hit_c),
    .count(match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed vectors push expectations, a monitor pops and compares.
module tb_seq_detector_param;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LEN_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic [LEN_W-1:0] pat_len = '0;
  logic             overlap = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             armed;
  logic             match;
  logic             cfg_err;
  logic [CNT_W-1:0] match_cnt;

  seq_detector_param #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .pat_len  (pat_len),
    .overlap  (overlap),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .cnt_clr  (cnt_clr),
    .armed    (armed),
    .match    (match),
    .cfg_err  (cfg_err),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic             armed;
    logic             match;
    logic             cfg_err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Counter expectation collapses to zero when the counter is not built.
  function automatic logic [CNT_W-1:0] ecnt(input int n);
`ifdef SEQDET_MATCH_CNT_EN
    return CNT_W'(n);
`else
    return CNT_W'(n * 0);
`endif
  endfunction

  function automatic void check_outputs(input exp_t e);
    vectors++;
    if (armed !== e.armed || match !== e.match || cfg_err !== e.cfg_err || match_cnt !== e.cnt) begin
      miscompares++;
      $display("FAIL %s: got armed=%b match=%b cfg_err=%b cnt=%0d, want armed=%b match=%b cfg_err=%b cnt=%0d",
               e.tag, armed, match, cfg_err, match_cnt, e.armed, e.match, e.cfg_err, e.cnt);
    end
  endfunction

  function automatic exp_t mk(input string tag, input logic a, input logic m, input logic c, input int n);
    exp_t e;
    e.tag     = tag;
    e.armed   = a;
    e.match   = m;
    e.cfg_err = c;
    e.cnt     = ecnt(n);
    return e;
  endfunction

  // One clocked cycle of stimulus; expectation describes outputs after this edge.
  task automatic step(input string tag, input logic pl, input logic [PAT_W-1:0] pin,
                      input logic [LEN_W-1:0] plen, input logic ov, input logic v, input logic b,
                      input logic clr, input logic ea, input logic em, input logic ec, input int en);
    pat_load = pl;
    pat_in   = pin;
    pat_len  = plen;
    overlap  = ov;
    in_valid = v;
    in_bit   = b;
    cnt_clr  = clr;
    @(posedge clk);
    exp_q.push_back(mk(tag, ea, em, ec, en));
    #1;
    pat_load = 1'b0;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic load(input string tag, input logic [PAT_W-1:0] pin, input logic [LEN_W-1:0] plen,
                      input logic ov, input logic clr, input logic ea, input logic ec, input int en);
    step(tag, 1'b1, pin, plen, ov, 1'b0, 1'b0, clr, ea, 1'b0, ec, en);
  endtask

  task automatic sbit(input string tag, input logic ov, input logic b, input logic clr,
                      input logic ea, input logic em, input int en);
    step(tag, 1'b0, '0, '0, ov, 1'b1, b, clr, ea, em, 1'b0, en);
  endtask

  // Monitor: compares one queued expectation per cycle, away from the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) check_outputs(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    check_outputs(mk("reset_state", 1'b0, 1'b0, 1'b0, 0));
    #9 reset = 1'b1;

    // Overlapping 1101 over 1101101: hits on bits 4 and 7.
    load("A_load", 4'b1101, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    sbit("A_b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    sbit("A_b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    sbit("A_b3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    sbit("A_b4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    sbit("A_b5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    sbit("A_b6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    sbit("A_b7", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    step("A_idle", 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);

    // Non-overlapping: only bit 4 hits.
    load("B_load", 4'b1101, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    sbit("B_b1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    sbit("B_b2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    sbit("B_b3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    sbit("B_b4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    sbit("B_b5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    sbit("B_b6", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    sbit("B_b7", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);

    // Pattern 11 (loaded as 1111, masked to 2 bits): every bit from the 2nd hits; counter saturates.
    load("C_load", 4'b1111, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    sbit("C_b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    sbit("C_b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    sbit("C_b3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    sbit("C_b4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    sbit("C_b5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    sbit("C_b6", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    sbit("C_b7", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    sbit("C_b8", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    sbit("C_clr_hit", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    sbit("C_after_clr", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);

    // Mid-stream reload to 0/len1 with a discarded coincident bit.
    sbit("D_b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    sbit("D_b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    sbit("D_b3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    step("D_reload", 1'b1, 4'b0000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    sbit("D_first0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3);

    // Asynchronous reset while match is high.
    #2 reset = 1'b0;
    #1 check_outputs(mk("E_async_rst", 1'b0, 1'b0, 1'b0, 0));
    @(posedge clk);
    #1 check_outputs(mk("E_rst_hold", 1'b0, 1'b0, 1'b0, 0));
    reset = 1'b1;
    sbit("E_post_b0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    sbit("E_post_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Illegal lengths while idle.
    load("F_len0", 4'b1101, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    sbit("F_b0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    load("F_len5", 4'b1101, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    sbit("F_s1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sbit("F_s2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sbit("F_s3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    sbit("F_s4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Illegal load while armed keeps the old pattern; then overlap switched off mid-stream.
    load("G_load", 4'b1101, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    load("G_len6", 4'b0000, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    sbit("G_b1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    sbit("G_b2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    sbit("G_b3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    sbit("G_b4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    sbit("G_b5", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    sbit("G_b6", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    sbit("G_b7", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2);
    sbit("G_b8", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    sbit("G_b9", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    sbit("G_b10", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2);

    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector for the control-path FSM library. It accepts one bit per valid cycle and flags when the most recent bits equal a runtime-loaded pattern of programmable length. Overlapping or non-overlapping detection is selectable at runtime, and an optional saturating match counter is available. It supersedes the fixed-pattern, hand-coded detector FSMs in the block library.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2)
- CNT_W, 16: match-counter width
- LEN_W, $clog2(PAT_W+1): derived; width of pattern-length field

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-low
- pat_load  in  1  load pat_in/pat_len this cycle
- pat_in  in  PAT_W  pattern; bit [len-1] is first-received bit, bit [0] is last-received bit
- pat_len  in  LEN_W  pattern length, legal range 1..PAT_W
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every valid cycle
- in_valid  in  1  in_bit is valid this cycle
- in_bit  in  1  serial data bit
- cnt_clr  in  1  synchronous clear of match_cnt
- armed  out  1  legal pattern loaded; detector running
- match  out  1  registered one-cycle pulse on detection
- cfg_err  out  1  one-cycle pulse; pat_load had illegal pat_len
- match_cnt  out  CNT_W  saturating match count

## Operation
- FSM states:
  - IDLE: no legal pattern loaded; input is ignored.
  - RUN: detecting.
- Reset (reset=0, asynchronous) forces IDLE, history=0, fill=0, pattern=0, len=0, and all outputs to 0.
- pat_load with 1 ≤ pat_len ≤ PAT_W:
  - Latch the pattern, masked to len bits.
  - Clear history and fill.
  - Go to RUN.
- pat_load with an illegal pat_len (0 or >PAT_W):
  - Assert cfg_err for one cycle.
  - Leave state, pattern and len unchanged.
- pat_load has priority over in_valid in the same cycle. That cycle's in_bit is discarded.
- RUN, in_valid=1:
  - history ← {history[PAT_W-2:0], in_bit}.
  - fill ← min(fill+1, PAT_W).
- Hit condition: fill_next ≥ len and history_next[len-1:0] == pattern[len-1:0].
- On a hit:
  - match=1 next cycle.
  - If overlap=0, fill ← 0 (history kept but unusable until refilled).
  - If overlap=1, fill is unchanged, so shared suffix bits count toward the next match.
- in_valid=0: no state change; match=0.
- armed = (state==RUN).
- Counter: match_cnt increments on each hit and saturates at 2^CNT_W−1.
  - cnt_clr has priority over a coincident hit; result is 0.
  - cnt_clr does not affect detection.

## Timing
- Latency: match is asserted the cycle after the rising edge that accepted the completing bit (1 cycle).
- match_cnt updates on the same edge as match.
- Back-to-back valid bits are supported every cycle. Maximum match rate is 1 per cycle (overlap=1 with a length-1 pattern, or with an all-ones/all-zeros pattern).
- Reload mid-stream: the first match is possible no earlier than len valid bits after the load cycle.
- Changing overlap mid-stream affects only hits evaluated in that cycle or later.
- Reset asserted mid-stream aborts immediately. Outputs are 0 while reset=0.

## Configuration
- SEQDET_MATCH_CNT_EN:
  - Defined: counter logic and cnt_clr behaviour as above.
  - Undefined: no counter flops; match_cnt tied to 0 and cnt_clr ignored. Port list is unchanged.

## Structure
- Package seqdet_pkg holds:
  - The state enum typedef (SD_IDLE, SD_RUN).
  - A function that computes the length-mask from len.
- Sub-module seqdet_sat_counter (CNT_W-parameterised saturating counter with clear/increment). It is instantiated only under SEQDET_MATCH_CNT_EN.

## Test plan
- PAT_W=4, load 1101/len 4, overlap=1, stream 1,1,0,1,1,0,1 → match after bits 4 and 7; match_cnt=2.
- Same load, overlap=0, same stream → match after bit 4 only; match_cnt=1.
- Load pat_len=0, then pat_len=5 (PAT_W=4) → cfg_err pulses each time; armed stays 0; input stream produces no match.
- Load 11/len 2, overlap=1, eight consecutive 1s → match on bits 2–8 (7 pulses). With CNT_W=2, match_cnt saturates at 3.
- Mid-stream reload: after bits 1,1,0, load 0/len 1 together with in_valid=1 and in_bit=0 → no match that cycle; the next valid 0 matches one cycle later.
- Assert reset mid-stream with match pending → match, armed and match_cnt drop to 0 asynchronously. After release, no match until a new pat_load.
